// File: rtl/countdown_timer_if.sv
// Handshake bundle for countdown_timer.
// Ports: start/D/CE/abort/reload in, Q/busy/done out (slave view).
interface countdown_timer_if #(
    parameter int N = 3
);
    logic         start;
    logic [N-1:0] D;
    logic         CE;
    logic         abort;
    logic         reload;
    logic [N-1:0] Q;
    logic         busy;
    logic         done;

    modport master (
        output start, D, CE, abort, reload,
        input  Q, busy, done
    );

    modport slave (
        input  start, D, CE, abort, reload,
        output Q, busy, done
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable N-bit down-counter with start/busy/done handshake, used to
// hold the pipeline stalled for a programmed number of enabled cycles.
// Ports: clk, reset (sync, active-high), bus (countdown_timer_if.slave):
//   start, D[N-1:0], CE, abort, reload -> Q[N-1:0], busy, done.
// Optional macro AUTO_RELOAD_EN: reload latched at start re-arms the
// count at terminal count instead of finishing.
module countdown_timer #(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             reset,
    countdown_timer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t       state, state_n;
    logic [N-1:0] q, q_n;
    logic         done_r, done_n;

`ifdef AUTO_RELOAD_EN
    logic [N-1:0] k_r, k_n;
    logic         rl_r, rl_n;
`else
    logic         unused_reload;
    assign unused_reload = bus.reload;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            q      <= '0;
            done_r <= 1'b0;
`ifdef AUTO_RELOAD_EN
            k_r    <= '0;
            rl_r   <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            q      <= q_n;
            done_r <= done_n;
`ifdef AUTO_RELOAD_EN
            k_r    <= k_n;
            rl_r   <= rl_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        q_n     = q;
        done_n  = 1'b0;
`ifdef AUTO_RELOAD_EN
        k_n     = k_r;
        rl_n    = rl_r;
`endif
        if (bus.abort) begin
            // Abort wins even over a coinciding terminal count.
            state_n = IDLE;
            q_n     = '0;
`ifdef AUTO_RELOAD_EN
            rl_n    = 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start && bus.D != '0) begin
                        state_n = RUN;
                        q_n     = bus.D;
`ifdef AUTO_RELOAD_EN
                        k_n     = bus.D;
                        rl_n    = bus.reload;
`endif
                    end else if (bus.start) begin
                        // Zero-length request completes immediately.
                        state_n = DONE;
                        q_n     = '0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = IDLE;
                        q_n     = '0;
                    end
                end
                RUN: begin
                    if (bus.CE) begin
                        if (q == ONE) begin
                            done_n = 1'b1;
`ifdef AUTO_RELOAD_EN
                            if (rl_r) begin
                                // Re-arm: stay busy, pulse done.
                                q_n = k_r;
                            end else begin
                                q_n     = '0;
                                state_n = DONE;
                            end
`else
                            q_n     = '0;
                            state_n = DONE;
`endif
                        end else if (q != '0) begin
                            q_n = q - ONE;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    q_n     = '0;
                end
            endcase
        end
    end

    assign bus.Q    = q;
    assign bus.busy = (state == RUN);
    assign bus.done = done_r;
endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (N=3).
// Covers count, CE gaps, D=0/max, abort, reset, back-to-back, reload.
module tb_countdown_timer;
    logic clk;
    logic reset;
    int   nchk;
    int   nerr;

    countdown_timer_if #(.N(3)) bus ();

    countdown_timer #(.N(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input int q, input int b,
                        input int d);
        chk({tag, ".Q"}, int'(bus.Q), q);
        chk({tag, ".busy"}, int'(bus.busy), b);
        chk({tag, ".done"}, int'(bus.done), d);
    endtask

    int cq[5];
    int rq[7];
    int rb[7];
    int rd[7];
    int nb;
    int nd;

    initial begin
        nchk = 0;
        nerr = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.D = 3'd0;
        bus.CE = 1'b0;
        bus.abort = 1'b0;
        bus.reload = 1'b0;
        tick();
        tick();
        chk3("reset", 0, 0, 0);
        reset = 1'b0;
        tick();
        chk3("idle", 0, 0, 0);

        // D=5, CE held high
        bus.start = 1'b1;
        bus.D = 3'd5;
        bus.CE = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk3($sformatf("d5.c%0d", i), 5 - i, 1, 0);
            tick();
        end
        chk3("d5.end", 0, 0, 1);
        tick();
        chk3("d5.post", 0, 0, 0);

        // D=3, CE 1,0,1,0,1
        cq = '{2, 2, 1, 1, 0};
        bus.start = 1'b1;
        bus.D = 3'd3;
        tick();
        bus.start = 1'b0;
        chk3("ce.load", 3, 1, 0);
        for (int i = 0; i < 5; i++) begin
            bus.CE = (i % 2 == 0);
            tick();
            chk3($sformatf("ce.c%0d", i), cq[i],
                 (i < 4) ? 1 : 0, (i == 4) ? 1 : 0);
        end
        bus.CE = 1'b1;
        tick();
        chk3("ce.post", 0, 0, 0);

        // D=0: immediate done, never busy
        bus.start = 1'b1;
        bus.D = 3'd0;
        tick();
        bus.start = 1'b0;
        chk3("d0", 0, 0, 1);
        tick();
        chk3("d0.post", 0, 0, 0);

        // D=7 (max): busy exactly 7 cycles, one done
        bus.start = 1'b1;
        bus.D = 3'd7;
        tick();
        bus.start = 1'b0;
        chk("d7.load", int'(bus.Q), 7);
        nb = int'(bus.busy);
        nd = int'(bus.done);
        for (int i = 0; i < 10; i++) begin
            tick();
            nb += int'(bus.busy);
            nd += int'(bus.done);
        end
        chk("d7.busycnt", nb, 7);
        chk("d7.donecnt", nd, 1);

        // D=4, restart ignored in RUN, abort at Q=2
        bus.start = 1'b1;
        bus.D = 3'd4;
        tick();
        chk3("ab.load", 4, 1, 0);
        bus.D = 3'd6;
        tick();
        chk3("ab.ign", 3, 1, 0);
        bus.start = 1'b0;
        tick();
        chk3("ab.q2", 2, 1, 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk3("ab.hit", 0, 0, 0);
        tick();
        chk3("ab.post", 0, 0, 0);

        // reset mid-RUN at Q=3
        bus.start = 1'b1;
        bus.D = 3'd5;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk3("rs.q3", 3, 1, 0);
        reset = 1'b1;
        tick();
        chk3("rs.hit", 0, 0, 0);
        reset = 1'b0;
        tick();
        chk3("rs.post", 0, 0, 0);

        // back-to-back: start in DONE cycle
        bus.start = 1'b1;
        bus.D = 3'd2;
        tick();
        bus.start = 1'b0;
        chk3("bb.load", 2, 1, 0);
        tick();
        chk3("bb.q1", 1, 1, 0);
        tick();
        chk3("bb.gap", 0, 0, 1);
        bus.start = 1'b1;
        bus.D = 3'd3;
        tick();
        bus.start = 1'b0;
        chk3("bb.again", 3, 1, 0);
        tick();
        tick();
        tick();
        chk3("bb.end", 0, 0, 1);
        tick();

        // reload request with D=3
`ifdef AUTO_RELOAD_EN
        rq = '{3, 2, 1, 3, 2, 1, 3};
        rb = '{1, 1, 1, 1, 1, 1, 1};
        rd = '{0, 0, 0, 1, 0, 0, 1};
`else
        rq = '{3, 2, 1, 0, 0, 0, 0};
        rb = '{1, 1, 1, 0, 0, 0, 0};
        rd = '{0, 0, 0, 1, 0, 0, 0};
`endif
        bus.start = 1'b1;
        bus.reload = 1'b1;
        bus.D = 3'd3;
        for (int i = 0; i < 7; i++) begin
            tick();
            bus.start = 1'b0;
            bus.reload = 1'b0;
            chk3($sformatf("rl.c%0d", i), rq[i], rb[i], rd[i]);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk3("rl.abort", 0, 0, 0);
        tick();
        chk3("rl.post", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable N-bit down-counter with a start/busy/done handshake. It is the counterpart of the pipeline's up-counter: the up-counter counts events upward from a loaded value, and this block counts a loaded value down to zero and reports completion. The control unit uses it to hold the pipeline stalled for a programmed number of enabled cycles during multi-cycle operations such as multiply/divide or memory wait states. It is a single-clock-domain block sitting next to the hazard/stall logic.

## Interface
Parameters:
- N, 3, counter width in bits

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request to load D and begin counting; honoured only when not busy
- D  input  N  cycle count to run (unsigned)
- CE  input  1  count enable; decrement happens only in cycles with CE=1
- abort  input  1  cancel the current count, return to idle, no done pulse
- reload  input  1  auto-reload request, sampled together with start (see Configuration)
- Q  output  N  current remaining count (registered)
- busy  output  1  high while state is RUN; drives the stall request
- done  output  1  one-cycle completion pulse (registered)

## Operation
- States: IDLE, RUN, DONE. The 2-bit state register is internal.
- Reset (synchronous; highest priority): state=IDLE, Q=0, busy=0, done=0, latched reload value and reload flag cleared.
- Priority on each edge: reset > abort > terminal count / start > decrement > hold.
- IDLE or DONE, start=1, D>0: Q<=D, state<=RUN. The latch also captures D and reload.
- IDLE or DONE, start=1, D=0: Q<=0, state<=DONE. This produces an immediate done pulse and never enters RUN. reload is ignored.
- IDLE or DONE, start=0: state<=IDLE, Q holds 0.
- DONE lasts exactly one cycle. done=1 exactly when state==DONE, or on a reload event (see Configuration).
- RUN, CE=1, Q>1: Q<=Q-1.
- RUN, CE=1, Q==1 (terminal count): Q<=0, state<=DONE.
- RUN, CE=0: Q and state hold. The CE=0 cycles extend the busy window.
- RUN, start=1: start is ignored and no restart occurs. The requester must wait for busy=0.
- abort=1 in any state: next cycle state=IDLE, Q=0, done=0. This applies even if a terminal count coincides with the abort.
- Arithmetic is unsigned, N bits. Q never wraps below 0 because a decrement occurs only when Q≥1. D=2^N−1 is legal.

## Timing
- start sampled in cycle t with D=k>0 and CE held high:
  - cycle t+1: Q=k, busy=1.
  - cycles t+1..t+k: decrement.
  - cycle t+k+1: Q=0, busy=0, done=1.
  - cycle t+k+2: IDLE, done=0.
- busy is high for exactly k cycles, plus one cycle for each CE=0 cycle inside RUN.
- start with D=0 in cycle t: done=1 in cycle t+1, and busy stays 0.
- A start sampled in the DONE cycle is accepted. Back-to-back operations therefore have a 1-cycle gap in busy.
- abort in cycle t: busy=0 and Q=0 in cycle t+1.
- Reset asserted mid-RUN: all outputs are 0 in the following cycle, and no done is produced.

## Configuration
- Macro AUTO_RELOAD_EN.
- Defined: if reload=1 was latched at start with D=k>0, then at terminal count (RUN, CE=1, Q==1):
  - Q<=k and state stays RUN;
  - done=1 for that one cycle while busy stays 1;
  - the resulting period is k enabled cycles per done pulse;
  - the sequence is left only by abort or reset.
- Not defined: the reload input is ignored (no reload register is built), and every terminal count goes to DONE.

## Test plan
- N=3, reset then start with D=5 and CE=1 → Q: 5,4,3,2,1 with busy=1 for 5 cycles; next cycle Q=0, done=1, busy=0; the cycle after, done=0.
- start with D=3, CE toggled 1,0,1,0,1 → busy lasts 5 cycles, Q holds during CE=0 cycles, and done appears after the third enabled cycle.
- start with D=0 → done=1 in the next cycle and busy never rises; start with D=7 → busy for exactly 7 cycles.
- start with D=4, abort at Q=2 → next cycle Q=0, busy=0, and no done pulse. start asserted again during RUN is ignored (Q keeps decrementing).
- Reset asserted while Q=3 in RUN → next cycle Q=0, busy=0, done=0. start in the DONE cycle of a previous run → accepted with a 1-cycle busy gap.
- With AUTO_RELOAD_EN defined, start with D=3 and reload=1 → done pulses every 3 cycles with busy constantly 1 and Q cycling 3,2,1,3,…; abort stops it. Without the macro, the same stimulus gives a single done pulse.
